// File: rtl/ibex_fetch_pkg.sv
// Types and constants shared by the fetch requester and its tag queue.
package ibex_fetch_pkg;

   localparam int unsigned FETCH_WORD_BYTES = 4;

   typedef struct packed {
      logic [31:0] addr;
      logic        discard;
   } fetch_tag_t;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      HALT
   } fetch_req_state_e;

endpackage

// File: rtl/ibex_fetch_tag_queue.sv
// Two-entry in-order queue of fetch tags, one per granted, unanswered bus request.
module ibex_fetch_tag_queue
   import ibex_fetch_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       push_i,
   input  fetch_tag_t push_tag_i,
   input  logic       pop_i,
   input  logic       discard_all_i,
   output fetch_tag_t head_o,
   output logic [1:0] count_o,
   output logic [1:0] count_next_o
);

   localparam int unsigned DEPTH = 2;

   fetch_tag_t entry_q [DEPTH];
   fetch_tag_t entry_d [DEPTH];
   logic [1:0] count_q, count_d, count_popped;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      entry_d      = entry_q;
      count_popped = count_q;
      if (pop_i && (count_q != 2'd0)) begin
         entry_d[0]   = entry_q[1];
         count_popped = count_q - 2'd1;
      end
      count_d = count_popped;
      if (push_i && (count_popped < 2'(DEPTH))) begin
         entry_d[count_popped[0]] = push_tag_i;
         count_d                  = count_popped + 2'd1;
      end
      // A request granted in the same cycle as the flush is marked too.
      if (discard_all_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            entry_d[i].discard = 1'b1;
         end
      end
   end

   // NOTE: tag storage is reset along with the count so head_o is defined out of reset.
   // NOTE: flops use <= so every register samples its pre-edge inputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= 2'd0;
         for (int i = 0; i < DEPTH; i++) begin
            entry_q[i] <= '0;
         end
      end else begin
         count_q <= count_d;
         entry_q <= entry_d;
      end
   end

   assign head_o       = entry_q[0];
   assign count_o      = count_q;
   assign count_next_o = count_d;

endmodule

// File: rtl/ibex_fetch_requester.sv
// Write side of the prefetch FIFO: issues word fetches on the instruction bus and
// pushes tagged responses, discarding stale words after a branch.
module ibex_fetch_requester
   import ibex_fetch_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        fetch_en_i,
   input  logic        branch_i,
   input  logic [31:0] branch_addr_i,
   output logic        instr_req_o,
   output logic [31:0] instr_addr_o,
   input  logic        instr_gnt_i,
   input  logic        instr_rvalid_i,
   input  logic [31:0] instr_rdata_i,
   input  logic        instr_err_i,
   output logic        fifo_clear_o,
   output logic        fifo_valid_o,
   output logic [31:0] fifo_addr_o,
   output logic [31:0] fifo_rdata_o,
   input  logic        fifo_ready_i,
   output logic        fetch_err_o,
   output logic [31:0] fetch_err_addr_o
);

   localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

   fetch_req_state_e state_q, state_d;
   logic [31:0]      fetch_addr_q, fetch_addr_d;
   logic [31:0]      pend_addr_q, pend_addr_d;
   logic             pend_valid_q, pend_valid_d;
   logic             halt_q, halt_d;

   fetch_tag_t head_tag, push_tag;
   logic [1:0] count, count_next;
   logic       req_granted, req_stalled, head_live, issue_ok;

   assign req_granted = (state_q == REQ) && instr_gnt_i;
   assign req_stalled = (state_q == REQ) && !instr_gnt_i;

   // A response counts only if it belongs to the current, un-halted stream.
   assign head_live = instr_rvalid_i && (count != 2'd0) && !head_tag.discard
                      && !halt_q && !branch_i;

   assign push_tag.addr    = fetch_addr_q;
   assign push_tag.discard = pend_valid_q || branch_i;

   ibex_fetch_tag_queue u_tag_queue (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .push_i        (req_granted),
      .push_tag_i    (push_tag),
      .pop_i         (instr_rvalid_i),
      .discard_all_i (branch_i),
      .head_o        (head_tag),
      .count_o       (count),
      .count_next_o  (count_next)
   );

   always_comb begin
      halt_d       = branch_i ? 1'b0 : (halt_q || (head_live && instr_err_i));
      issue_ok     = fetch_en_i && fifo_ready_i && (count_next < MAX_CNT) && !halt_d;
      fetch_addr_d = fetch_addr_q;
      pend_addr_d  = pend_addr_q;
      pend_valid_d = pend_valid_q;

      // The bus address must not move under an ungranted request, so park the target.
      if (branch_i && req_stalled) begin
         pend_valid_d = 1'b1;
         pend_addr_d  = branch_addr_i;
      end else if (branch_i) begin
         fetch_addr_d = branch_addr_i;
         pend_valid_d = 1'b0;
      end else if (req_granted) begin
         fetch_addr_d = pend_valid_q ? pend_addr_q : fetch_addr_q + 32'(FETCH_WORD_BYTES);
         pend_valid_d = 1'b0;
      end

      state_d = state_q;
      case (state_q)
         REQ: begin
            if (instr_gnt_i) begin
               state_d = issue_ok ? REQ : (halt_d ? HALT : IDLE);
            end
         end
         default: state_d = issue_ok ? REQ : (halt_d ? HALT : IDLE);
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         fetch_addr_q <= 32'd0;
         pend_addr_q  <= 32'd0;
         pend_valid_q <= 1'b0;
         halt_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_addr_q <= fetch_addr_d;
         pend_addr_q  <= pend_addr_d;
         pend_valid_q <= pend_valid_d;
         halt_q       <= halt_d;
      end
   end

   assign instr_req_o      = (state_q == REQ);
   assign instr_addr_o     = {fetch_addr_q[31:2], 2'b00};
   assign fifo_clear_o     = branch_i;
   assign fifo_valid_o     = head_live && !instr_err_i;
   assign fifo_addr_o      = fifo_valid_o ? head_tag.addr : 32'd0;
   assign fifo_rdata_o     = fifo_valid_o ? instr_rdata_i : 32'd0;
   assign fetch_err_o      = head_live && instr_err_i;
   assign fetch_err_addr_o = fetch_err_o ? head_tag.addr : 32'd0;

   // A response with nothing outstanding means the bus broke protocol.
   rvalid_needs_request : assert property (@(posedge clk_i) disable iff (rst_i)
      instr_rvalid_i |-> (count != 2'd0));

endmodule

// File: tb/tb_ibex_fetch_requester.sv
// Bench for ibex_fetch_requester: directed vector table, hand-written corner
// sequences, then random traffic checked against a fetch-stream model.
module tb_ibex_fetch_requester;

   localparam int unsigned MAX_OUT = 2;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        fetch_en_i = 1'b0, branch_i = 1'b0, fifo_ready_i = 1'b0;
   logic [31:0] branch_addr_i = 32'd0;
   logic        instr_gnt_i = 1'b0, instr_rvalid_i = 1'b0, instr_err_i = 1'b0;
   logic [31:0] instr_rdata_i = 32'd0;
   logic        instr_req_o, fifo_clear_o, fifo_valid_o, fetch_err_o;
   logic [31:0] instr_addr_o, fifo_addr_o, fifo_rdata_o, fetch_err_addr_o;

   always #5 clk_i = ~clk_i;

   ibex_fetch_requester #(.MAX_OUTSTANDING(MAX_OUT)) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .fetch_en_i       (fetch_en_i),
      .branch_i         (branch_i),
      .branch_addr_i    (branch_addr_i),
      .instr_req_o      (instr_req_o),
      .instr_addr_o     (instr_addr_o),
      .instr_gnt_i      (instr_gnt_i),
      .instr_rvalid_i   (instr_rvalid_i),
      .instr_rdata_i    (instr_rdata_i),
      .instr_err_i      (instr_err_i),
      .fifo_clear_o     (fifo_clear_o),
      .fifo_valid_o     (fifo_valid_o),
      .fifo_addr_o      (fifo_addr_o),
      .fifo_rdata_o     (fifo_rdata_o),
      .fifo_ready_i     (fifo_ready_i),
      .fetch_err_o      (fetch_err_o),
      .fetch_err_addr_o (fetch_err_addr_o)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_b(input string name, input logic act, input logic exp);
      check(name, {31'd0, act}, {31'd0, exp});
   endtask

   typedef struct {
      logic        fen, br;
      logic [31:0] baddr;
      logic        rdy, gnt, rv;
      logic [31:0] rdata;
      logic        err;
      logic        req;
      logic [31:0] addr;
      logic        clr, valid;
      logic [31:0] faddr;
      logic        ferr;
      logic [31:0] eaddr;
   } vec_t;

   function automatic vec_t v(
      input logic fen, input logic br, input logic [31:0] baddr, input logic rdy,
      input logic gnt, input logic rv, input logic [31:0] rdata, input logic err,
      input logic req, input logic [31:0] addr, input logic clr, input logic valid,
      input logic [31:0] faddr, input logic ferr, input logic [31:0] eaddr);
      vec_t t;
      t.fen = fen; t.br = br; t.baddr = baddr; t.rdy = rdy; t.gnt = gnt; t.rv = rv;
      t.rdata = rdata; t.err = err; t.req = req; t.addr = addr; t.clr = clr;
      t.valid = valid; t.faddr = faddr; t.ferr = ferr; t.eaddr = eaddr;
      return t;
   endfunction

   // Drive one cycle of inputs just after the falling edge, compare, advance.
   task automatic run_vec(input string tag, input vec_t t);
      fetch_en_i = t.fen; branch_i = t.br; branch_addr_i = t.baddr; fifo_ready_i = t.rdy;
      instr_gnt_i = t.gnt; instr_rvalid_i = t.rv; instr_rdata_i = t.rdata; instr_err_i = t.err;
      #1;
      check_b({tag, ".req"}, instr_req_o, t.req);
      if (t.req) check({tag, ".addr"}, instr_addr_o, t.addr);
      check_b({tag, ".clear"}, fifo_clear_o, t.clr);
      check_b({tag, ".push"}, fifo_valid_o, t.valid);
      if (t.valid) begin
         check({tag, ".push_addr"}, fifo_addr_o, t.faddr);
         check({tag, ".push_data"}, fifo_rdata_o, t.rdata);
      end
      check_b({tag, ".err"}, fetch_err_o, t.ferr);
      if (t.ferr) check({tag, ".err_addr"}, fetch_err_addr_o, t.eaddr);
      @(negedge clk_i);
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   vec_t        tbl [14];
   logic [31:0] bus_q [$];
   logic [31:0] stream_next, prev_addr;
   bit          halted, req_new, prev_req, prev_gnt, prev_fen, prev_rdy;
   int          pushes;

   initial begin
      // Straight-line fetch after a branch to 0x80, then a halfword target 0x102.
      tbl[0]  = v(1, 1, 'h80,  1, 0, 0, 0,            0, 0, 0,      1, 0, 0,      0, 0);
      tbl[1]  = v(1, 0, 0,     1, 1, 0, 0,            0, 1, 'h80,   0, 0, 0,      0, 0);
      tbl[2]  = v(1, 0, 0,     1, 1, 1, 'hD000_0080,  0, 1, 'h84,   0, 1, 'h80,   0, 0);
      tbl[3]  = v(1, 0, 0,     1, 1, 1, 'hD000_0084,  0, 1, 'h88,   0, 1, 'h84,   0, 0);
      tbl[4]  = v(0, 0, 0,     1, 0, 1, 'hD000_0088,  0, 1, 'h8C,   0, 1, 'h88,   0, 0);
      tbl[5]  = v(0, 0, 0,     1, 1, 0, 0,            0, 1, 'h8C,   0, 0, 0,      0, 0);
      tbl[6]  = v(0, 0, 0,     1, 0, 1, 'hD000_008C,  0, 0, 0,      0, 1, 'h8C,   0, 0);
      tbl[7]  = v(0, 0, 0,     1, 0, 0, 0,            0, 0, 0,      0, 0, 0,      0, 0);
      tbl[8]  = v(1, 1, 'h102, 1, 0, 0, 0,            0, 0, 0,      1, 0, 0,      0, 0);
      tbl[9]  = v(1, 0, 0,     1, 1, 0, 0,            0, 1, 'h100,  0, 0, 0,      0, 0);
      tbl[10] = v(1, 0, 0,     1, 1, 1, 'hB000_0102,  0, 1, 'h104,  0, 1, 'h102,  0, 0);
      tbl[11] = v(0, 0, 0,     1, 0, 1, 'hB000_0106,  0, 1, 'h108,  0, 1, 'h106,  0, 0);
      tbl[12] = v(0, 0, 0,     1, 1, 0, 0,            0, 1, 'h108,  0, 0, 0,      0, 0);
      tbl[13] = v(0, 0, 0,     1, 0, 1, 'hB000_010A,  0, 0, 0,      0, 1, 'h10A,  0, 0);

      repeat (2) @(negedge clk_i);
      #1;
      check_b("reset.req", instr_req_o, 1'b0);
      check("reset.addr", instr_addr_o, 32'd0);
      check_b("reset.clear", fifo_clear_o, 1'b0);
      check_b("reset.push", fifo_valid_o, 1'b0);
      check("reset.push_addr", fifo_addr_o, 32'd0);
      check("reset.push_data", fifo_rdata_o, 32'd0);
      check_b("reset.err", fetch_err_o, 1'b0);
      check("reset.err_addr", fetch_err_addr_o, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;

      for (int i = 0; i < 14; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

      // Grant withheld at 0x84, branch to 0x200 while waiting.
      run_vec("hold0", v(1, 1, 'h84,  1, 0, 0, 0,           0, 0, 0,     1, 0, 0,     0, 0));
      run_vec("hold1", v(1, 0, 0,     1, 0, 0, 0,           0, 1, 'h84,  0, 0, 0,     0, 0));
      run_vec("hold2", v(1, 1, 'h200, 1, 0, 0, 0,           0, 1, 'h84,  1, 0, 0,     0, 0));
      run_vec("hold3", v(1, 0, 0,     1, 0, 0, 0,           0, 1, 'h84,  0, 0, 0,     0, 0));
      run_vec("hold4", v(1, 0, 0,     1, 1, 0, 0,           0, 1, 'h84,  0, 0, 0,     0, 0));
      run_vec("hold5", v(1, 0, 0,     1, 0, 1, 'hDEAD_0084, 0, 1, 'h200, 0, 0, 0,     0, 0));
      run_vec("hold6", v(0, 0, 0,     1, 1, 0, 0,           0, 1, 'h200, 0, 0, 0,     0, 0));
      run_vec("hold7", v(0, 0, 0,     1, 0, 1, 'hC000_0200, 0, 0, 0,     0, 1, 'h200, 0, 0));

      // Two outstanding at 0x10/0x14, branch to 0x40 drops both.
      run_vec("two0", v(1, 1, 'h10, 1, 0, 0, 0,           0, 0, 0,    1, 0, 0,    0, 0));
      run_vec("two1", v(1, 0, 0,    1, 1, 0, 0,           0, 1, 'h10, 0, 0, 0,    0, 0));
      run_vec("two2", v(1, 0, 0,    1, 1, 0, 0,           0, 1, 'h14, 0, 0, 0,    0, 0));
      run_vec("two3", v(1, 1, 'h40, 1, 0, 0, 0,           0, 0, 0,    1, 0, 0,    0, 0));
      run_vec("two4", v(1, 0, 0,    1, 0, 1, 'hDEAD_0010, 0, 0, 0,    0, 0, 0,    0, 0));
      run_vec("two5", v(0, 0, 0,    1, 1, 1, 'hDEAD_0014, 0, 1, 'h40, 0, 0, 0,    0, 0));
      run_vec("two6", v(0, 0, 0,    1, 0, 1, 'hC000_0040, 0, 0, 0,    0, 1, 'h40, 0, 0));

      // Bus error on 0x24 halts fetching until a branch.
      run_vec("err0",  v(1, 1, 'h20,  1, 0, 0, 0,           0, 0, 0,     1, 0, 0,     0, 0));
      run_vec("err1",  v(1, 0, 0,     1, 1, 0, 0,           0, 1, 'h20,  0, 0, 0,     0, 0));
      run_vec("err2",  v(1, 0, 0,     1, 1, 1, 'hC000_0020, 0, 1, 'h24,  0, 1, 'h20,  0, 0));
      run_vec("err3",  v(1, 0, 0,     1, 0, 1, 'hDEAD_0024, 1, 1, 'h28,  0, 0, 0,     1, 'h24));
      run_vec("err4",  v(1, 0, 0,     1, 1, 0, 0,           0, 1, 'h28,  0, 0, 0,     0, 0));
      run_vec("err5",  v(1, 0, 0,     1, 0, 1, 'hC000_0028, 0, 0, 0,     0, 0, 0,     0, 0));
      run_vec("err6",  v(1, 0, 0,     1, 0, 0, 0,           0, 0, 0,     0, 0, 0,     0, 0));
      run_vec("err7",  v(1, 0, 0,     1, 0, 0, 0,           0, 0, 0,     0, 0, 0,     0, 0));
      run_vec("err8",  v(1, 1, 'h300, 1, 0, 0, 0,           0, 0, 0,     1, 0, 0,     0, 0));
      run_vec("err9",  v(0, 0, 0,     1, 1, 0, 0,           0, 1, 'h300, 0, 0, 0,     0, 0));
      run_vec("err10", v(0, 0, 0,     1, 0, 1, 'hC000_0300, 0, 0, 0,     0, 1, 'h300, 0, 0));

      // FIFO not ready: no issue, in-flight response still lands.
      run_vec("rdy0", v(1, 1, 'h400, 1, 0, 0, 0,           0, 0, 0,     1, 0, 0,     0, 0));
      run_vec("rdy1", v(1, 0, 0,     0, 1, 0, 0,           0, 1, 'h400, 0, 0, 0,     0, 0));
      run_vec("rdy2", v(1, 0, 0,     0, 0, 1, 'hC000_0400, 0, 0, 0,     0, 1, 'h400, 0, 0));
      run_vec("rdy3", v(1, 0, 0,     0, 0, 0, 0,           0, 0, 0,     0, 0, 0,     0, 0));
      run_vec("rdy4", v(1, 0, 0,     1, 0, 0, 0,           0, 0, 0,     0, 0, 0,     0, 0));
      run_vec("rdy5", v(0, 0, 0,     1, 1, 0, 0,           0, 1, 'h404, 0, 0, 0,     0, 0));
      run_vec("rdy6", v(0, 0, 0,     1, 0, 1, 'hC000_0404, 0, 0, 0,     0, 1, 'h404, 0, 0));

      // Random traffic: the FIFO must see a gap-free word stream from the last branch target.
      stream_next = 32'd0; halted = 1'b0; pushes = 0;
      prev_req = 1'b0; prev_gnt = 1'b0; prev_fen = 1'b0; prev_rdy = 1'b0; prev_addr = 32'd0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         fetch_en_i    = ($urandom_range(0, 7) != 0);
         fifo_ready_i  = ($urandom_range(0, 5) != 0);
         branch_i      = (cyc == 0) || ($urandom_range(0, 24) == 0);
         branch_addr_i = {22'd0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0};
         instr_gnt_i   = instr_req_o && ($urandom_range(0, 3) != 0);
         instr_rvalid_i = (bus_q.size() != 0) && ($urandom_range(0, 2) != 0);
         instr_rdata_i = 32'd0;
         if (instr_rvalid_i) instr_rdata_i = mem_word(bus_q[0]);
         instr_err_i   = instr_rvalid_i && ($urandom_range(0, 19) == 0);
         #1;
         req_new = instr_req_o && !(prev_req && !prev_gnt);
         if (prev_req && !prev_gnt) begin
            check_b("rnd.req_held", instr_req_o, 1'b1);
            check("rnd.addr_held", instr_addr_o, prev_addr);
         end
         if (instr_req_o) check("rnd.addr_align", {30'd0, instr_addr_o[1:0]}, 32'd0);
         if (halted) check_b("rnd.halt_no_req", req_new, 1'b0);
         if (!(prev_rdy && prev_fen)) check_b("rnd.gate_no_req", req_new, 1'b0);
         check_b("rnd.clear", fifo_clear_o, branch_i);
         if (branch_i || halted) begin
            check_b("rnd.stale_push", fifo_valid_o, 1'b0);
            check_b("rnd.stale_err", fetch_err_o, 1'b0);
         end
         if (!instr_rvalid_i || instr_err_i) check_b("rnd.push_gate", fifo_valid_o, 1'b0);
         if (!(instr_rvalid_i && instr_err_i)) check_b("rnd.err_gate", fetch_err_o, 1'b0);
         if (fifo_valid_o) begin
            check("rnd.push_addr", fifo_addr_o, stream_next);
            check("rnd.push_data", fifo_rdata_o, mem_word(stream_next));
            stream_next = stream_next + 32'd4;
            pushes++;
         end
         if (fetch_err_o) begin
            check("rnd.err_addr", fetch_err_addr_o, stream_next);
            halted = 1'b1;
         end
         if (branch_i) begin
            stream_next = branch_addr_i;
            halted      = 1'b0;
         end
         if (instr_rvalid_i) void'(bus_q.pop_front());
         if (instr_req_o && instr_gnt_i) bus_q.push_back(instr_addr_o);
         check_b("rnd.outstanding", bus_q.size() <= MAX_OUT, 1'b1);
         prev_req = instr_req_o; prev_gnt = instr_gnt_i; prev_addr = instr_addr_o;
         prev_fen = fetch_en_i;  prev_rdy = fifo_ready_i;
         @(negedge clk_i);
      end
      check_b("rnd.progress", pushes > 20, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
